seven_segment_mux: RTL

//  Parametrised time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.

---
 rtl/sevseg_pkg.sv | 47 ++++
 rtl/sevseg_hex_decoder.sv | 11 +
 rtl/seven_segment_mux.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared seven-segment constants: active-high patterns for hex 0-F (bit 0 = top ... bit 6 = middle)
// and the hex-to-segment lookup used by the decoder.
package sevseg_pkg;

   localparam logic [6:0] SEG_0   = 7'b0111111;
   localparam logic [6:0] SEG_1   = 7'b0000110;
   localparam logic [6:0] SEG_2   = 7'b1011011;
   localparam logic [6:0] SEG_3   = 7'b1001111;
   localparam logic [6:0] SEG_4   = 7'b1100110;
   localparam logic [6:0] SEG_5   = 7'b1101101;
   localparam logic [6:0] SEG_6   = 7'b1111101;
   localparam logic [6:0] SEG_7   = 7'b0000111;
   localparam logic [6:0] SEG_8   = 7'b1111111;
   localparam logic [6:0] SEG_9   = 7'b1101111;
   localparam logic [6:0] SEG_A   = 7'b1110111;
   localparam logic [6:0] SEG_B   = 7'b1111100;
   localparam logic [6:0] SEG_C   = 7'b0111001;
   localparam logic [6:0] SEG_D   = 7'b1011110;
   localparam logic [6:0] SEG_E   = 7'b1111001;
   localparam logic [6:0] SEG_F   = 7'b1110001;
   localparam logic [6:0] SEG_OFF = 7'b0000000;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      seg = SEG_OFF;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sevseg_hex_decoder.sv
// Combinational 4-bit hex to 7-segment decode, always active-high; the top applies pin polarity.
module sevseg_hex_decoder
   import sevseg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit 7-segment driver: prescaled scan, frame-coherent shadow inputs, PWM
// brightness, dead cycle per slot. Define SEVSEG_LZ_BLANK_EN to auto-blank leading zeros.
module seven_segment_mux #(
   parameter int NUM_DIGITS      = 4,
   parameter int PRESCALE_W      = 4,
   parameter int BRIGHT_W        = 2,
   parameter int SEG_ACTIVE_HIGH = 1,
   parameter int EN_ACTIVE_LOW   = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [6:0]              segments,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   enable,
   output logic                    frame_start
);
   import sevseg_pkg::*;

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PRESCALE_W-1:0] P_MAX    = {PRESCALE_W{1'b1}};
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_UNLIT = (SEG_ACTIVE_HIGH != 0) ? SEG_OFF : ~SEG_OFF;
   localparam logic       DP_UNLIT  = (SEG_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
   localparam logic [NUM_DIGITS-1:0] EN_IDLE =
      (EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [PRESCALE_W-1:0]   p_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [4*NUM_DIGITS-1:0] digits_sh_reg;
   logic [NUM_DIGITS-1:0]   dp_sh_reg;
   logic [NUM_DIGITS-1:0]   blank_sh_reg;
   logic [BRIGHT_W-1:0]     bright_sh_reg;
   logic [NUM_DIGITS-1:0]   blank_load;

   logic [6:0]              seg_next;
   logic                    dp_next;
   logic [NUM_DIGITS-1:0]   en_next;
   logic [NUM_DIGITS-1:0]   en_onehot;
   logic                    frame_next;

   logic                    slot_end;
   logic                    frame_wrap;
   logic                    lit;
   logic [3:0]              digit_arr [NUM_DIGITS];
   logic [3:0]              cur_digit;
   logic [6:0]              cur_seg;

   assign slot_end   = (p_reg == P_MAX);
   assign frame_wrap = slot_end && (idx_reg == IDX_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         p_reg   <= '0;
         idx_reg <= '0;
      end else begin
         p_reg <= p_reg + 1'b1;
         if (slot_end)
            idx_reg <= frame_wrap ? '0 : idx_reg + 1'b1;
      end
   end

`ifdef SEVSEG_LZ_BLANK_EN
   // zero_from[i]: digit i and every digit above it are zero
   logic [NUM_DIGITS:1]   zero_from;
   logic [NUM_DIGITS-1:0] lz_blank;

   assign zero_from[NUM_DIGITS] = 1'b1;
   assign lz_blank[0]           = 1'b0;
   for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_from[gi] = (digits[4*gi +: 4] == 4'h0) && zero_from[gi+1];
      assign lz_blank[gi]  = zero_from[gi] && !dp[gi];
   end
   assign blank_load = blank | lz_blank;
`else
   assign blank_load = blank;
`endif

   // Shadow copy taken only as the scan wraps to (0,0), so a frame never shows mixed inputs
   always_ff @(posedge clock) begin
      if (reset) begin
         digits_sh_reg <= '0;
         dp_sh_reg     <= '0;
         blank_sh_reg  <= '1;
         bright_sh_reg <= '0;
      end else if (frame_wrap) begin
         digits_sh_reg <= digits;
         dp_sh_reg     <= dp;
         blank_sh_reg  <= blank_load;
         bright_sh_reg <= brightness;
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_sh_reg[4*gi +: 4];
   end
   assign cur_digit = digit_arr[idx_reg];

   sevseg_hex_decoder u_hex_decoder (
      .hex (cur_digit),
      .seg (cur_seg)
   );

   assign lit = !blank_sh_reg[idx_reg]
             && (p_reg[PRESCALE_W-1 -: BRIGHT_W] <= bright_sh_reg)
             && !slot_end;

   always_comb begin
      seg_next   = SEG_UNLIT;
      dp_next    = DP_UNLIT;
      en_next    = EN_IDLE;
      en_onehot  = '0;
      en_onehot[idx_reg] = 1'b1;
      frame_next = (idx_reg == '0) && (p_reg == '0);
      if (lit) begin
         seg_next = (SEG_ACTIVE_HIGH != 0) ? cur_seg : ~cur_seg;
         dp_next  = (SEG_ACTIVE_HIGH != 0) ? dp_sh_reg[idx_reg] : ~dp_sh_reg[idx_reg];
         en_next  = (EN_ACTIVE_LOW != 0) ? ~en_onehot : en_onehot;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         segments    <= SEG_UNLIT;
         dp_out      <= DP_UNLIT;
         enable      <= EN_IDLE;
         frame_start <= 1'b0;
      end else begin
         segments    <= seg_next;
         dp_out      <= dp_next;
         enable      <= en_next;
         frame_start <= frame_next;
      end
   end

endmodule
